// File: rtl/fish_alarm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fish_alarm_pkg : shared states, source codes and pattern helper   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package fish_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_MUTE = 2'd3
  } state_t;

  // Lower code means higher priority.
  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_GAS   = 2'd1;
  localparam logic [1:0] SRC_TEMP  = 2'd2;
  localparam logic [1:0] SRC_LEVEL = 2'd3;

  function automatic int unsigned off_len(input logic [1:0] src, input int unsigned off_ticks);
    return (src == SRC_LEVEL) ? 3 * off_ticks : off_ticks;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alarm_debounce : 2-FF synchroniser plus tick-based level filter   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module alarm_debounce
  import fish_alarm_pkg::*;
#(
  parameter int DEB_TICKS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic dout
);

  localparam int              c_cw   = $clog2(DEB_TICKS + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(DEB_TICKS - 1);

  logic            r_s1;
  logic            r_s2;
  logic            r_dout;
  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_dout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      if (r_s2 == r_dout) begin
        r_cnt <= '0;
      end else if (tick) begin
        // The tick that completes DEB_TICKS stable ticks accepts the level.
        if (r_cnt == c_last) begin
          r_dout <= r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/fish_alarm_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fish_alarm_scheduler : priority buzzer sharing for gas/temp/level |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fish_alarm_scheduler #(
  parameter int TICK_DIV   = 50000,
  parameter int DEB_TICKS  = 20,
  parameter int ON_TICKS   = 200,
  parameter int OFF_TICKS  = 300,
  parameter int MUTE_TICKS = 30000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mq2_data,
  input  logic       temp_alarm,
  input  logic       level_alarm,
  input  logic       ack,
  output logic       buzzer,
  output logic [1:0] active_src,
  output logic       muted
);

  import fish_alarm_pkg::*;

  localparam int c_pw        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_phase_max = (ON_TICKS > 3 * OFF_TICKS) ? ON_TICKS : 3 * OFF_TICKS;
  localparam int c_hw        = $clog2(c_phase_max + 1);
  localparam int c_mw        = $clog2(MUTE_TICKS + 1);

  localparam logic [c_pw-1:0] c_pre_last   = c_pw'(TICK_DIV - 1);
  localparam logic [c_hw-1:0] c_on_last    = c_hw'(ON_TICKS - 1);
  localparam logic [c_hw-1:0] c_off_last_t = c_hw'(off_len(SRC_TEMP, OFF_TICKS) - 1);
  localparam logic [c_hw-1:0] c_off_last_l = c_hw'(off_len(SRC_LEVEL, OFF_TICKS) - 1);
  localparam logic [c_mw-1:0] c_mute_load  = c_mw'(MUTE_TICKS);

  logic [c_pw-1:0] r_pre;
  logic            w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_pre <= '0;
    else if (r_pre == c_pre_last) r_pre <= '0;
    else                         r_pre <= r_pre + 1'b1;
  end

  assign w_tick = (r_pre == c_pre_last);

  logic w_gas;
  logic w_temp;
  logic w_level;

  alarm_debounce #(.DEB_TICKS(DEB_TICKS)) u_gas (
    .clk(clk), .rst_n(rst_n), .tick(w_tick), .din(mq2_data), .dout(w_gas)
  );
  alarm_debounce #(.DEB_TICKS(DEB_TICKS)) u_temp (
    .clk(clk), .rst_n(rst_n), .tick(w_tick), .din(temp_alarm), .dout(w_temp)
  );
  alarm_debounce #(.DEB_TICKS(DEB_TICKS)) u_level (
    .clk(clk), .rst_n(rst_n), .tick(w_tick), .din(level_alarm), .dout(w_level)
  );

  state_t          r_state, w_state;
  logic [1:0]      r_cur, w_cur;
  logic [1:0]      r_msrc, w_msrc;
  logic [c_hw-1:0] r_phase, w_phase;
  logic [c_mw-1:0] r_mute, w_mute;
  logic [1:0]      w_sel;
  logic            w_cur_act;
  logic            w_preempt;
  logic [c_hw-1:0] w_off_last;
  logic [1:0]      w_src;

  always_comb begin
    w_sel = SRC_NONE;
    if (w_gas)        w_sel = SRC_GAS;
    else if (w_temp)  w_sel = SRC_TEMP;
    else if (w_level) w_sel = SRC_LEVEL;
  end

  always_comb begin
    w_cur_act = 1'b0;
    case (r_cur)
      SRC_GAS:   w_cur_act = w_gas;
      SRC_TEMP:  w_cur_act = w_temp;
      SRC_LEVEL: w_cur_act = w_level;
      default:   w_cur_act = 1'b0;
    endcase
  end

  assign w_preempt  = (w_sel != SRC_NONE) && (w_sel < r_cur);
  assign w_off_last = (r_cur == SRC_LEVEL) ? c_off_last_l : c_off_last_t;

  always_comb begin
    w_state = r_state;
    w_cur   = r_cur;
    w_msrc  = r_msrc;
    w_phase = r_phase;
    w_mute  = r_mute;
    case (r_state)
      ST_IDLE: begin
        if (w_sel != SRC_NONE) begin
          w_state = ST_ON;
          w_cur   = w_sel;
          w_phase = '0;
        end
      end
      ST_ON, ST_OFF: begin
        // Event priority: preempt, then source drop, then ack.
        if (w_preempt) begin
          w_state = ST_ON;
          w_cur   = w_sel;
          w_phase = '0;
        end else if (!w_cur_act) begin
          w_phase = '0;
          if (w_sel != SRC_NONE) begin
            w_state = ST_ON;
            w_cur   = w_sel;
          end else begin
            w_state = ST_IDLE;
          end
        end else if (ack) begin
          w_state = ST_MUTE;
          w_msrc  = r_cur;
          w_mute  = c_mute_load;
        end else if (r_state == ST_ON) begin
          // Gas sounds continuously, so its phase counter never runs.
          if ((r_cur != SRC_GAS) && w_tick) begin
            if (r_phase == c_on_last) begin
              w_state = ST_OFF;
              w_phase = '0;
            end else begin
              w_phase = r_phase + 1'b1;
            end
          end
        end else if (w_tick) begin
          if (r_phase == w_off_last) begin
            w_state = ST_ON;
            w_phase = '0;
          end else begin
            w_phase = r_phase + 1'b1;
          end
        end
      end
      ST_MUTE: begin
        if ((w_sel != SRC_NONE) && (w_sel < r_msrc)) begin
          w_state = ST_ON;
          w_cur   = w_sel;
          w_phase = '0;
        end else if ((r_mute == '0) || (w_sel == SRC_NONE)) begin
          w_state = ST_IDLE;
        end else if (w_tick) begin
          w_mute = r_mute - 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_src = SRC_NONE;
    case (w_state)
      ST_ON, ST_OFF: w_src = w_cur;
      ST_MUTE:       w_src = w_msrc;
      default:       w_src = SRC_NONE;
    endcase
  end

  logic       r_buzzer;
  logic [1:0] r_src;
  logic       r_muted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cur    <= SRC_NONE;
      r_msrc   <= SRC_NONE;
      r_phase  <= '0;
      r_mute   <= '0;
      r_buzzer <= 1'b1;
      r_src    <= SRC_NONE;
      r_muted  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cur    <= w_cur;
      r_msrc   <= w_msrc;
      r_phase  <= w_phase;
      r_mute   <= w_mute;
      r_buzzer <= (w_state != ST_ON);
      r_src    <= w_src;
      r_muted  <= (w_state == ST_MUTE);
    end
  end

  assign buzzer     = r_buzzer;
  assign active_src = r_src;
  assign muted      = r_muted;

endmodule
`default_nettype wire

// File: tb/tb_fish_alarm_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fish_alarm_scheduler : directed vectors and timed corner cases |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_fish_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mq2_data = 1'b0;
  logic       temp_alarm = 1'b0;
  logic       level_alarm = 1'b0;
  logic       ack = 1'b0;
  logic       buzzer;
  logic [1:0] active_src;
  logic       muted;

  fish_alarm_scheduler #(
    .TICK_DIV(4), .DEB_TICKS(3), .ON_TICKS(2), .OFF_TICKS(3), .MUTE_TICKS(10)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .mq2_data(mq2_data), .temp_alarm(temp_alarm),
    .level_alarm(level_alarm), .ack(ack), .buzzer(buzzer),
    .active_src(active_src), .muted(muted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       gas;
    logic       temp;
    logic       level;
    int         hold;
    logic [1:0] src;
    logic       chk_buz;
    logic       buz;
  } vec_t;

  localparam int SIG_BUZ = 0;
  localparam int SIG_MUTED = 1;
  localparam int SIG_SRC = 2;

  vec_t tv[10];
  int   n_run = 0;
  int   n_fail = 0;
  int   e = 0;  // posedges since the last reset release

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  function automatic int sig(input int which);
    case (which)
      SIG_BUZ:   return int'(buzzer);
      SIG_MUTED: return int'(muted);
      default:   return int'(active_src);
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      e++;
    end
  endtask

  task automatic to_edge(input int t);
    while (e < t) step(1);
  endtask

  // Called at a negedge; returns at the negedge of release with e = 0.
  task automatic do_reset();
    rst_n = 1'b0;
    mq2_data = 1'b0; temp_alarm = 1'b0; level_alarm = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
  endtask

  task automatic wait_sig(input int which, input int val, input int budget,
                          input string name, output int took);
    took = 0;
    while (sig(which) != val && took < budget) begin
      step(1);
      took++;
    end
    if (sig(which) != val) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: no change within %0d cycles, got %0d expected %0d",
               name, budget, sig(which), val);
    end
  endtask

  task automatic run_len(input int which, input int val, input int maxc, output int len);
    len = 1;
    while (len < maxc) begin
      step(1);
      if (sig(which) != val) break;
      len++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int took, len, bad;

    tv[0] = '{1'b0, 1'b0, 1'b0, 20, 2'd0, 1'b1, 1'b1};
    tv[1] = '{1'b1, 1'b0, 1'b0, 20, 2'd1, 1'b1, 1'b0};
    tv[2] = '{1'b1, 1'b1, 1'b0, 20, 2'd1, 1'b1, 1'b0};
    tv[3] = '{1'b1, 1'b1, 1'b1, 20, 2'd1, 1'b1, 1'b0};
    tv[4] = '{1'b0, 1'b1, 1'b1, 20, 2'd2, 1'b0, 1'b0};
    tv[5] = '{1'b0, 1'b0, 1'b1, 20, 2'd3, 1'b0, 1'b0};
    tv[6] = '{1'b1, 1'b0, 1'b1, 20, 2'd1, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b0, 1'b0, 20, 2'd0, 1'b1, 1'b1};
    tv[8] = '{1'b0, 1'b1, 1'b0, 20, 2'd2, 1'b0, 1'b0};
    tv[9] = '{1'b0, 1'b0, 1'b0, 20, 2'd0, 1'b1, 1'b1};

    // Reset values, both while held and just after release.
    @(negedge clk);
    chk("rst_buz", buzzer, 1);
    chk("rst_src", active_src, 0);
    chk("rst_muted", muted, 0);
    do_reset();
    step(2);
    chk("post_rst_buz", buzzer, 1);
    chk("post_rst_src", active_src, 0);

    // Steady-state selection table.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mq2_data = tv[i].gas; temp_alarm = tv[i].temp; level_alarm = tv[i].level;
      step(tv[i].hold);
      chk($sformatf("vec%0d_src", i), active_src, tv[i].src);
      chk($sformatf("vec%0d_muted", i), muted, 0);
      if (tv[i].chk_buz) chk($sformatf("vec%0d_buz", i), buzzer, tv[i].buz);
    end

    // Glitch of two ticks is rejected; a held level is accepted.
    do_reset();
    mq2_data = 1'b1;
    bad = 0;
    for (int k = 0; k < 38; k++) begin
      step(1);
      if (e == 8) mq2_data = 1'b0;
      if (buzzer != 1'b1 || active_src != 2'd0) bad++;
    end
    chk("glitch_quiet", bad, 0);
    to_edge(40);
    mq2_data = 1'b1;
    wait_sig(SIG_BUZ, 0, 30, "gas_on_wait", took);
    chk("gas_on_latency", took, 13);
    chk("gas_on_src", active_src, 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (buzzer != 1'b0 || active_src != 2'd1) bad++;
    end
    chk("gas_continuous", bad, 0);
    to_edge(80);
    mq2_data = 1'b0;
    wait_sig(SIG_SRC, 0, 30, "gas_off_wait", took);
    chk("gas_off_latency", took, 13);
    chk("gas_off_buz", buzzer, 1);

    // Temperature beep pattern.
    do_reset();
    temp_alarm = 1'b1;
    wait_sig(SIG_BUZ, 0, 30, "temp_on_wait", took);
    chk("temp_on_latency", took, 13);
    chk("temp_src", active_src, 2);
    run_len(SIG_BUZ, 0, 100, len); chk("temp_first_on", len, 7);
    run_len(SIG_BUZ, 1, 100, len); chk("temp_off1", len, 12);
    run_len(SIG_BUZ, 0, 100, len); chk("temp_on2", len, 8);
    run_len(SIG_BUZ, 1, 100, len); chk("temp_off2", len, 12);

    // Level beep pattern.
    do_reset();
    level_alarm = 1'b1;
    wait_sig(SIG_BUZ, 0, 30, "level_on_wait", took);
    chk("level_src", active_src, 3);
    run_len(SIG_BUZ, 0, 100, len); chk("level_first_on", len, 7);
    run_len(SIG_BUZ, 1, 100, len); chk("level_off1", len, 36);
    run_len(SIG_BUZ, 0, 100, len); chk("level_on2", len, 8);
    run_len(SIG_BUZ, 1, 100, len); chk("level_off2", len, 36);

    // Gas preempts temp while temp is in its off phase.
    do_reset();
    temp_alarm = 1'b1;
    to_edge(17); mq2_data = 1'b1;
    to_edge(28);
    chk("pre_before_src", active_src, 2);
    chk("pre_before_buz", buzzer, 1);
    step(1);
    chk("pre_src", active_src, 1);
    chk("pre_buz", buzzer, 0);
    to_edge(40);
    chk("pre_hold_src", active_src, 1);
    mq2_data = 1'b0;
    to_edge(52);
    chk("pre_rel_before", active_src, 1);
    step(1);
    chk("pre_rel_src", active_src, 2);
    chk("pre_rel_buz", buzzer, 0);
    run_len(SIG_BUZ, 0, 100, len); chk("pre_rel_on_len", len, 7);

    // Mute of temp runs out, a second ack in mute is ignored.
    do_reset();
    temp_alarm = 1'b1;
    to_edge(14); ack = 1'b1;
    step(1); ack = 1'b0;
    chk("mute_muted", muted, 1);
    chk("mute_buz", buzzer, 1);
    chk("mute_src", active_src, 2);
    to_edge(30); ack = 1'b1;
    step(1); ack = 1'b0;
    to_edge(52);
    chk("mute_end_muted", muted, 1);
    step(1);
    chk("mute_idle_muted", muted, 0);
    chk("mute_idle_src", active_src, 0);
    chk("mute_idle_buz", buzzer, 1);
    step(1);
    chk("mute_reon_buz", buzzer, 0);
    chk("mute_reon_src", active_src, 2);

    // Gas breaks through a temp mute.
    do_reset();
    temp_alarm = 1'b1;
    to_edge(14); ack = 1'b1;
    step(1); ack = 1'b0; mq2_data = 1'b1;
    to_edge(28);
    chk("mgas_before_muted", muted, 1);
    step(1);
    chk("mgas_muted", muted, 0);
    chk("mgas_src", active_src, 1);
    chk("mgas_buz", buzzer, 0);

    // Level cannot break through a temp mute.
    do_reset();
    temp_alarm = 1'b1;
    to_edge(14); ack = 1'b1;
    step(1); ack = 1'b0; level_alarm = 1'b1;
    to_edge(35);
    chk("mlvl_muted", muted, 1);
    chk("mlvl_src", active_src, 2);
    chk("mlvl_buz", buzzer, 1);
    to_edge(53);
    chk("mlvl_end_muted", muted, 0);
    step(1);
    chk("mlvl_reon_src", active_src, 2);
    chk("mlvl_reon_buz", buzzer, 0);

    // Ack in the same cycle as a gas preempt loses to the preempt.
    do_reset();
    temp_alarm = 1'b1;
    to_edge(3); mq2_data = 1'b1;
    to_edge(16);
    chk("sim_before_src", active_src, 2);
    chk("sim_before_buz", buzzer, 0);
    ack = 1'b1;
    step(1); ack = 1'b0;
    chk("sim_muted", muted, 0);
    chk("sim_src", active_src, 1);
    chk("sim_buz", buzzer, 0);

    // Ack in idle has no lasting effect.
    do_reset();
    to_edge(2); ack = 1'b1;
    step(1); ack = 1'b0;
    chk("idle_ack_muted", muted, 0);
    chk("idle_ack_src", active_src, 0);
    temp_alarm = 1'b1;
    to_edge(16);
    chk("idle_ack_pre_src", active_src, 0);
    step(1);
    chk("idle_ack_on_buz", buzzer, 0);
    chk("idle_ack_on_muted", muted, 0);

    // Asynchronous reset mid-beep, then re-debounce from scratch.
    do_reset();
    mq2_data = 1'b1;
    to_edge(20);
    chk("ar_on_buz", buzzer, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_buz", buzzer, 1);
    chk("ar_src", active_src, 0);
    chk("ar_muted", muted, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    to_edge(12);
    chk("ar_redeb_quiet", buzzer, 1);
    step(1);
    chk("ar_redeb_buz", buzzer, 0);
    chk("ar_redeb_src", active_src, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
